// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: opcodes, datapath function
// codes, ARF register indices, sequencer state enum and the control bundle
// that the decoder hands to the top level.
package control_sequencer_pkg;

  // Opcodes (IROut[15:10])
  localparam logic [5:0] OP_BRA = 6'h00;
  localparam logic [5:0] OP_BNE = 6'h01;
  localparam logic [5:0] OP_BEQ = 6'h02;
  localparam logic [5:0] OP_LDI = 6'h10;
  localparam logic [5:0] OP_ADD = 6'h11;
  localparam logic [5:0] OP_SUB = 6'h12;
  localparam logic [5:0] OP_AND = 6'h13;
  localparam logic [5:0] OP_ORR = 6'h14;
  localparam logic [5:0] OP_XOR = 6'h15;

  // ALU operations (16-bit variants)
  localparam logic [4:0] ALU_ADD = 5'h14;
  localparam logic [4:0] ALU_SUB = 5'h16;
  localparam logic [4:0] ALU_AND = 5'h17;
  localparam logic [4:0] ALU_ORR = 5'h18;
  localparam logic [4:0] ALU_XOR = 5'h19;

  // Register file / address register file functions
  localparam logic [2:0] RF_INC   = 3'b001;
  localparam logic [2:0] RF_LOAD  = 3'b010;
  localparam logic [2:0] RF_CLR   = 3'b011;
  localparam logic [1:0] ARF_INC  = 2'b01;
  localparam logic [1:0] ARF_LOAD = 2'b10;
  localparam logic [1:0] ARF_CLR  = 2'b11;

  // ARF read-select indices and the PC write enable
  localparam logic [1:0] ARF_PC    = 2'b00;
  localparam logic [1:0] ARF_AR    = 2'b10;
  localparam logic [1:0] ARF_SP    = 2'b11;
  localparam logic [2:0] ARF_EN_PC = 3'b100;

  typedef enum logic [1:0] {FETCH_L, FETCH_H, EXEC, HALT} state_t;

  typedef struct packed {
    logic [2:0] rf_outa_sel;
    logic [2:0] rf_outb_sel;
    logic [2:0] rf_funsel;
    logic [3:0] rf_regsel;
    logic [3:0] rf_scrsel;
    logic [4:0] alu_funsel;
    logic       alu_wf;
    logic [1:0] arf_outc_sel;
    logic [1:0] arf_outd_sel;
    logic [1:0] arf_funsel;
    logic [2:0] arf_regsel;
    logic       ir_lh;
    logic       ir_write;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] dr_funsel;
    logic       dr_e;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic [1:0] mux_c_sel;
    logic       mux_d_sel;
  } ctrl_t;

  // Register index 0 selects R1, which sits in the MSB of the enable vector.
  function automatic logic [3:0] rf_onehot(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

  function automatic logic is_alu_op(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_ORR) || (op == OP_XOR);
  endfunction

  function automatic logic [4:0] alu_fun(input logic [5:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_ORR:  return ALU_ORR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_seq_decoder.sv
// Combinational step decoder: maps sequencer state, timing step, instruction
// register and the Z flag onto the full datapath control bundle.
// Ports:
//   state_i       current sequencer state
//   t_i           current timing step
//   ir_i          instruction register contents
//   flag_z_i      ALU zero flag
//   ctrl_o        control bundle (before stall/reset masking)
//   exec_more_o   instruction needs a second execute step (T3)
//   halt_req_o    halt opcode decoded in T2
module control_sequencer_seq_decoder
  import control_sequencer_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
  input  state_t      state_i,
  input  logic [2:0]  t_i,
  input  logic [15:0] ir_i,
  input  logic        flag_z_i,
  output ctrl_t       ctrl_o,
  output logic        exec_more_o,
  output logic        halt_req_o
);

  logic [5:0] opcode;
  logic       is_t2;
  logic       is_t3;
  logic       branch_taken;

  assign opcode = ir_i[15:10];
  assign is_t2  = (state_i == EXEC) && (t_i == 3'd2);
  assign is_t3  = (state_i == EXEC) && (t_i == 3'd3);

  assign exec_more_o = is_t2 && is_alu_op(opcode);
  assign halt_req_o  = is_t2 && (opcode == HALT_OPCODE);

  always_comb begin
    branch_taken = 1'b0;
    case (opcode)
      OP_BRA:  branch_taken = 1'b1;
      OP_BNE:  branch_taken = !flag_z_i;
      OP_BEQ:  branch_taken = flag_z_i;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH_L, FETCH_H: begin
        ctrl_o.mem_cs       = 1'b1;
        ctrl_o.mem_wr       = 1'b0;
        ctrl_o.arf_outd_sel = ARF_PC;
        ctrl_o.ir_write     = 1'b1;
        ctrl_o.ir_lh        = (state_i == FETCH_H);
        ctrl_o.arf_regsel   = ARF_EN_PC;
        ctrl_o.arf_funsel   = ARF_INC;
      end
      EXEC: begin
        if (is_t2) begin
          if (branch_taken) begin
            // Branch target comes from the IR immediate through mux B.
            ctrl_o.mux_b_sel  = 2'b11;
            ctrl_o.arf_regsel = ARF_EN_PC;
            ctrl_o.arf_funsel = ARF_LOAD;
          end else if (opcode == OP_LDI) begin
            ctrl_o.mux_a_sel = 2'b11;
            ctrl_o.rf_regsel = rf_onehot(ir_i[9:8]);
            ctrl_o.rf_funsel = RF_LOAD;
          end else if (is_alu_op(opcode)) begin
            ctrl_o.rf_outa_sel = ir_i[5:3];
            ctrl_o.rf_outb_sel = ir_i[2:0];
            ctrl_o.mux_d_sel   = 1'b0;
            ctrl_o.alu_funsel  = alu_fun(opcode);
            ctrl_o.alu_wf      = ir_i[9];
          end
        end else if (is_t3 && is_alu_op(opcode)) begin
          // Operand selects stay put so the ALU result is still valid for
          // the write-back through mux A.
          ctrl_o.rf_outa_sel = ir_i[5:3];
          ctrl_o.rf_outb_sel = ir_i[2:0];
          ctrl_o.mux_d_sel   = 1'b0;
          ctrl_o.alu_funsel  = alu_fun(opcode);
          ctrl_o.mux_a_sel   = 2'b00;
          ctrl_o.rf_regsel   = ir_i[8] ? 4'b0000 : rf_onehot(ir_i[7:6]);
          ctrl_o.rf_funsel   = RF_LOAD;
        end
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute controller for the ALU datapath system.
// Holds the sequencer state and timing step; control outputs are decoded
// combinationally from them plus IROut and ALU_Flags.
// Optional build macro CTRL_STALL_EN adds a Stall input that freezes the
// sequence and suppresses every enable while selects keep their values.
// Ports:
//   Clock, Reset      rising-edge clock, synchronous active-high reset
//   Stall             (CTRL_STALL_EN only) pause request
//   IROut, ALU_Flags  instruction register and {Z,C,N,O} flags
//   RF_*, ALU_*, ARF_*, IR_*, Mem_*, DR_*, Mux*Sel   datapath controls
//   T                 current timing step
//   Halted            high while stopped on the halt opcode
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
  input  logic        Clock,
  input  logic        Reset,
`ifdef CTRL_STALL_EN
  input  logic        Stall,
`endif
  input  logic [15:0] IROut,
  input  logic [3:0]  ALU_Flags,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  DR_FunSel,
  output logic        DR_E,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic [1:0]  MuxCSel,
  output logic        MuxDSel,
  output logic [2:0]  T,
  output logic        Halted
);

  state_t     state_q, state_d;
  logic [2:0] t_q, t_d;
  logic       stall;
  logic       exec_more;
  logic       halt_req;
  ctrl_t      ctrl_dec;
  ctrl_t      ctrl_out;
  logic       flags_unused;

`ifdef CTRL_STALL_EN
  assign stall = Stall;
`else
  assign stall = 1'b0;
`endif

  // Only Z steers the sequence; C, N and O belong to the datapath.
  assign flags_unused = ^ALU_Flags[2:0];

  control_sequencer_seq_decoder #(
    .HALT_OPCODE (HALT_OPCODE)
  ) u_seq_decoder (
    .state_i     (state_q),
    .t_i         (t_q),
    .ir_i        (IROut),
    .flag_z_i    (ALU_Flags[3]),
    .ctrl_o      (ctrl_dec),
    .exec_more_o (exec_more),
    .halt_req_o  (halt_req)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= FETCH_L;
      t_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    if (!stall) begin
      case (state_q)
        FETCH_L: begin
          state_d = FETCH_H;
          t_d     = 3'd1;
        end
        FETCH_H: begin
          state_d = EXEC;
          t_d     = 3'd2;
        end
        EXEC: begin
          if (halt_req) begin
            state_d = HALT;
          end else if (exec_more) begin
            t_d = 3'd3;
          end else begin
            state_d = FETCH_L;
            t_d     = 3'd0;
          end
        end
        default: begin
          state_d = HALT;
        end
      endcase
    end
  end

  // Reset blanks every control for the cycles it is held; the registered
  // state alone would otherwise already show the T0 fetch.
  always_comb begin
    ctrl_out = ctrl_dec;
    if (stall) begin
      ctrl_out.rf_regsel  = 4'b0000;
      ctrl_out.rf_scrsel  = 4'b0000;
      ctrl_out.arf_regsel = 3'b000;
      ctrl_out.ir_write   = 1'b0;
      ctrl_out.alu_wf     = 1'b0;
      ctrl_out.dr_e       = 1'b0;
      ctrl_out.mem_cs     = 1'b0;
    end
    if (Reset) begin
      ctrl_out = '0;
    end
  end

  assign RF_OutASel  = ctrl_out.rf_outa_sel;
  assign RF_OutBSel  = ctrl_out.rf_outb_sel;
  assign RF_FunSel   = ctrl_out.rf_funsel;
  assign RF_RegSel   = ctrl_out.rf_regsel;
  assign RF_ScrSel   = ctrl_out.rf_scrsel;
  assign ALU_FunSel  = ctrl_out.alu_funsel;
  assign ALU_WF      = ctrl_out.alu_wf;
  assign ARF_OutCSel = ctrl_out.arf_outc_sel;
  assign ARF_OutDSel = ctrl_out.arf_outd_sel;
  assign ARF_FunSel  = ctrl_out.arf_funsel;
  assign ARF_RegSel  = ctrl_out.arf_regsel;
  assign IR_LH       = ctrl_out.ir_lh;
  assign IR_Write    = ctrl_out.ir_write;
  assign Mem_WR      = ctrl_out.mem_wr;
  assign Mem_CS      = ctrl_out.mem_cs;
  assign DR_FunSel   = ctrl_out.dr_funsel;
  assign DR_E        = ctrl_out.dr_e;
  assign MuxASel     = ctrl_out.mux_a_sel;
  assign MuxBSel     = ctrl_out.mux_b_sel;
  assign MuxCSel     = ctrl_out.mux_c_sel;
  assign MuxDSel     = ctrl_out.mux_d_sel;
  assign T           = t_q;
  assign Halted      = (state_q == HALT);

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
`ifdef CTRL_STALL_EN
  logic        Stall = 1'b0;
`endif
  logic [15:0] IROut = 16'h0000;
  logic [3:0]  ALU_Flags = 4'b0000;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
  logic [1:0]  DR_FunSel;
  logic        DR_E;
  logic [1:0]  MuxASel, MuxBSel, MuxCSel;
  logic        MuxDSel;
  logic [2:0]  T;
  logic        Halted;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset),
`ifdef CTRL_STALL_EN
    .Stall(Stall),
`endif
    .IROut(IROut), .ALU_Flags(ALU_Flags),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel),
    .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .DR_FunSel(DR_FunSel), .DR_E(DR_E),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .MuxDSel(MuxDSel),
    .T(T), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] t;
    logic       halted;
    logic       mem_cs;
    logic       mem_wr;
    logic       ir_write;
    logic       ir_lh;
    logic [2:0] arf_regsel;
    logic [1:0] arf_funsel;
    logic [1:0] arf_outd;
    logic [1:0] muxa;
    logic [1:0] muxb;
    logic       muxd;
    logic [3:0] rf_regsel;
    logic [3:0] rf_scrsel;
    logic [2:0] rf_funsel;
    logic [2:0] outa;
    logic [2:0] outb;
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic       dr_e;
  } obs_t;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic [3:0]  fl;
    obs_t        o;
  } vec_t;

  typedef struct {
    string name;
    obs_t  o;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic obs_t sample();
    obs_t s;
    s.t = T; s.halted = Halted; s.mem_cs = Mem_CS; s.mem_wr = Mem_WR;
    s.ir_write = IR_Write; s.ir_lh = IR_LH; s.arf_regsel = ARF_RegSel;
    s.arf_funsel = ARF_FunSel; s.arf_outd = ARF_OutDSel; s.muxa = MuxASel;
    s.muxb = MuxBSel; s.muxd = MuxDSel; s.rf_regsel = RF_RegSel;
    s.rf_scrsel = RF_ScrSel; s.rf_funsel = RF_FunSel; s.outa = RF_OutASel;
    s.outb = RF_OutBSel; s.alu_fun = ALU_FunSel; s.alu_wf = ALU_WF; s.dr_e = DR_E;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  function automatic obs_t o_step(input logic [2:0] t);
    obs_t o;
    o = '0;
    o.t = t;
    return o;
  endfunction

  task automatic add(input string nm, input logic [15:0] ir, input logic [3:0] fl, input obs_t o);
    vec_t v;
    v.name = nm; v.ir = ir; v.fl = fl; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input string nm, input logic [15:0] ir, input logic [3:0] fl);
    obs_t o;
    o = o_step(3'd0);
    o.mem_cs = 1'b1; o.ir_write = 1'b1; o.arf_regsel = 3'b100;
    o.arf_funsel = ARF_INC; o.arf_outd = ARF_PC;
    add({nm, "_t0"}, ir, fl, o);
    o.t = 3'd1; o.ir_lh = 1'b1;
    add({nm, "_t1"}, ir, fl, o);
  endtask

  task automatic add_alu(input string nm, input logic [15:0] ir, input logic [4:0] fun,
                         input logic wf, input logic [2:0] a, input logic [2:0] b,
                         input logic [3:0] wr);
    obs_t o;
    add_fetch(nm, ir, 4'b0000);
    o = o_step(3'd2);
    o.outa = a; o.outb = b; o.alu_fun = fun; o.alu_wf = wf;
    add({nm, "_t2"}, ir, 4'b0000, o);
    o.t = 3'd3; o.alu_wf = 1'b0; o.rf_regsel = wr; o.rf_funsel = RF_LOAD;
    add({nm, "_t3"}, ir, 4'b0000, o);
  endtask

  task automatic add_branch(input string nm, input logic [15:0] ir, input logic [3:0] fl,
                            input logic taken);
    obs_t o;
    add_fetch(nm, ir, fl);
    o = o_step(3'd2);
    if (taken) begin
      o.muxb = 2'b11; o.arf_regsel = 3'b100; o.arf_funsel = ARF_LOAD;
    end
    add({nm, "_t2"}, ir, fl, o);
  endtask

  task automatic add_ldi(input string nm, input logic [15:0] ir, input logic [3:0] wr);
    obs_t o;
    add_fetch(nm, ir, 4'b0000);
    o = o_step(3'd2);
    o.muxa = 2'b11; o.rf_regsel = wr; o.rf_funsel = RF_LOAD;
    add({nm, "_t2"}, ir, 4'b0000, o);
  endtask

  // Scoreboard consumer: compares whatever the driver queued for this cycle.
  always @(negedge Clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, 64'(sample()), 64'(e.o));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int writes;
    // Vector table
    add_ldi("ldi_r1", 16'h4005, 4'b1000);
    add_ldi("ldi_r4", 16'h4300, 4'b0001);
    add_alu("add_s1", 16'h4653, ALU_ADD, 1'b1, 3'b010, 3'b011, 4'b0100);
    add_alu("add_s0", 16'h4453, ALU_ADD, 1'b0, 3'b010, 3'b011, 4'b0100);
    add_alu("sub_dst_s", 16'h490D, ALU_SUB, 1'b0, 3'b001, 3'b101, 4'b0000);
    add_alu("and", 16'h4E37, ALU_AND, 1'b1, 3'b110, 3'b111, 4'b1000);
    add_alu("orr", 16'h50A1, ALU_ORR, 1'b0, 3'b100, 3'b001, 4'b0010);
    add_alu("xor", 16'h56F8, ALU_XOR, 1'b1, 3'b111, 3'b000, 4'b0001);
    add_branch("beq_z0", 16'h0820, 4'b0000, 1'b0);
    add_branch("beq_z1", 16'h0820, 4'b1000, 1'b1);
    add_branch("bne_z1", 16'h0420, 4'b1000, 1'b0);
    add_branch("bne_z0", 16'h0420, 4'b0111, 1'b1);
    add_branch("bra", 16'h0012, 4'b0000, 1'b1);
    add_branch("undef", 16'h1005, 4'b0000, 1'b0);
    add_branch("halt", 16'hFC00, 4'b0000, 1'b0);

    // Reset, then reset again in the middle of a fetch
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    @(posedge Clock); #1;
    chk("fetch_h_t", 64'(T), 64'd1);
    chk("fetch_h_lh", 64'(IR_LH), 64'd1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("rst_t", 64'(T), 64'd0);
    chk("rst_ir_write", 64'(IR_Write), 64'd0);
    chk("rst_arf_regsel", 64'(ARF_RegSel), 64'd0);
    chk("rst_halted", 64'(Halted), 64'd0);
    chk("rst_all", 64'(sample()), 64'(obs_t'('0)));

    // Table-driven instruction stream
    foreach (vecs[i]) begin
      exp_t e;
      @(posedge Clock); #1;
      if (i == 0) Reset = 1'b0;
      IROut = vecs[i].ir;
      ALU_Flags = vecs[i].fl;
      e.name = vecs[i].name;
      e.o = vecs[i].o;
      sb.push_back(e);
    end

    // Halt: idle for 20 cycles, no PC increment
    @(posedge Clock);
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      chk("halt_flag", 64'(Halted), 64'd1);
      chk("halt_idle", 64'({T, IR_Write, Mem_CS, ARF_RegSel, RF_RegSel, ALU_WF}),
          64'({3'd2, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0}));
    end
    chk("halt_sb_empty", 64'(sb.size()), 64'd0);
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("halt_rst_t", 64'(T), 64'd0);
    chk("halt_rst_halted", 64'(Halted), 64'd0);
    chk("halt_rst_cs", 64'(Mem_CS), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    IROut = 16'h4653;
    #1;
    chk("resume_t0", 64'({T, IR_Write, IR_LH}), 64'({3'd0, 1'b1, 1'b0}));
    @(posedge Clock); #1;
    chk("resume_t1", 64'({T, IR_Write, IR_LH}), 64'({3'd1, 1'b1, 1'b1}));

`ifdef CTRL_STALL_EN
    @(posedge Clock); #1;
    chk("stall_pre_t2", 64'(T), 64'd2);
    @(posedge Clock); #1;
    Stall = 1'b1;
    writes = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      chk("stall_hold_t", 64'(T), 64'd3);
      chk("stall_regsel", 64'(RF_RegSel), 64'd0);
      chk("stall_sel_kept", 64'({RF_OutASel, RF_OutBSel}), 64'({3'b010, 3'b011}));
      if (RF_RegSel != 4'b0000) writes++;
      @(posedge Clock); #1;
    end
    Stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      if (k == 0) chk("stall_release_wr", 64'(RF_RegSel), 64'b0100);
      if (RF_RegSel != 4'b0000) writes++;
    end
    chk("stall_write_once", 64'(writes), 64'd1);
`else
    writes = 0;
    @(posedge Clock); #1;
    chk("nostall_t2", 64'(T), 64'd2);
    @(posedge Clock); #1;
    chk("nostall_t3", 64'(T), 64'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      if (RF_RegSel != 4'b0000) writes++;
    end
    chk("nostall_write_once", 64'(writes), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
